// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: cyclic priority search starting at ptr_reg, where
// the pointer stays on a requester for up to its weight in consecutive grants.
module weighted_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        allow_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*WEIGHT_W-1:0] weight_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic                        gnt_found_o,
    output logic [IDX_W-1:0]            gnt_idx_o
);

    logic [IDX_W-1:0]    ptr_reg, ptr_next;
    logic [WEIGHT_W-1:0] cnt_reg, cnt_next;

    logic [WEIGHT_W-1:0] w_eff [NUM_REQ];
    logic [IDX_W:0]      cand;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic                grant_valid;
    logic [WEIGHT_W:0]   tenure_c;

    // A zero weight field still earns one grant per visit.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_weight
            assign w_eff[gi] = (weight_i[gi*WEIGHT_W +: WEIGHT_W] == '0)
                             ? WEIGHT_W'(1) : weight_i[gi*WEIGHT_W +: WEIGHT_W];
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_reg} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!win_found && req_i[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign grant_valid = win_found && allow_i && !rst_i;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt_o[gi] = grant_valid && (win_idx == IDX_W'(gi));
        end
    endgenerate

    assign gnt_found_o = |gnt_o;
    assign gnt_idx_o   = grant_valid ? win_idx : '0;

    // A grant to anyone other than ptr_reg starts a fresh tenure at count 1,
    // which is how a dropped request forfeits its remaining credit.
    always_comb begin
        tenure_c = (win_idx == ptr_reg) ? ({1'b0, cnt_reg} + (WEIGHT_W+1)'(1))
                                        : (WEIGHT_W+1)'(1);
        ptr_next = ptr_reg;
        cnt_next = cnt_reg;
        if (grant_valid) begin
            if (tenure_c >= {1'b0, w_eff[win_idx]}) begin
                ptr_next = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
                cnt_next = '0;
            end else begin
                ptr_next = win_idx;
                cnt_next = tenure_c[WEIGHT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg <= '0;
            cnt_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Scoreboard bench for weighted_rr_arbiter: directed sequences, random traffic
// against a reference model, and a long all-ones run for grant shares.
module tb_weighted_rr_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          allow;
    logic [N-1:0]  req;
    logic [N*W-1:0] weight;
    logic [N-1:0]  gnt;
    logic          gnt_found;
    logic [1:0]    gnt_idx;

    logic [N*W-1:0] wcur;

    int checks = 0;
    int errors = 0;
    int fair_cnt [N];

    int    q_idx  [$];
    string q_tag  [$];
    bit    q_fair [$];
    bit    q_verb [$];

    int m_ptr = 0;
    int m_cnt = 0;

    weighted_rr_arbiter #(.NUM_REQ(N), .WEIGHT_W(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .allow_i    (allow),
        .req_i      (req),
        .weight_i   (weight),
        .gnt_o      (gnt),
        .gnt_found_o(gnt_found),
        .gnt_idx_o  (gnt_idx)
    );

    always #5 clk = ~clk;

    // Reference model: winner from current model state and applied inputs.
    function automatic int model_grant();
        int g;
        g = -1;
        if (!rst && allow) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && req[i]) g = i;
            end
        end
        return g;
    endfunction

    task automatic model_update(input int g);
        int w;
        int c;
        if (rst) begin
            m_ptr = 0;
            m_cnt = 0;
        end else if (g >= 0) begin
            w = int'(weight[g*W +: W]);
            if (w == 0) w = 1;
            c = (g == m_ptr) ? m_cnt + 1 : 1;
            if (c >= w) begin
                m_ptr = (g + 1) % N;
                m_cnt = 0;
            end else begin
                m_ptr = g;
                m_cnt = c;
            end
        end
    endtask

    // exp_idx = -1 means no grant expected; use_model substitutes the model's answer.
    task automatic drive(input logic r, input logic a, input logic [N-1:0] rq,
                         input int exp_idx, input string tag,
                         input bit use_model, input bit fair);
        int g;
        @(posedge clk);
        #1;
        rst    = r;
        allow  = a;
        req    = rq;
        weight = wcur;
        g = model_grant();
        q_idx.push_back(use_model ? g : exp_idx);
        q_tag.push_back(tag);
        q_fair.push_back(fair);
        q_verb.push_back(!use_model);
        model_update(g);
    endtask

    // Monitor: one expected entry per cycle, compared away from the active edge.
    initial begin
        int        e;
        string     t;
        bit        f;
        bit        v;
        logic [N-1:0] exp_gnt;
        forever begin
            @(negedge clk);
            if (q_idx.size() > 0) begin
                e = q_idx.pop_front();
                t = q_tag.pop_front();
                f = q_fair.pop_front();
                v = q_verb.pop_front();
                exp_gnt = (e >= 0) ? (N'(1) << e) : '0;
                checks++;
                if (gnt !== exp_gnt || gnt_found !== (e >= 0) ||
                    gnt_idx !== 2'((e >= 0) ? e : 0)) begin
                    errors++;
                    $display("FAIL %s: gnt_o=%b found=%b idx=%0d, expected gnt_o=%b found=%b idx=%0d",
                             t, gnt, gnt_found, gnt_idx, exp_gnt, (e >= 0), (e >= 0) ? e : 0);
                end else if (v) begin
                    $display("[%0t] %s: req=%b gnt_o=%b idx=%0d ok", $time, t, req, gnt, gnt_idx);
                end
                if (!rst) begin
                    checks++;
                    if ($countones(gnt) > 1 || gnt_found !== (|gnt) || (gnt & ~req) != '0) begin
                        errors++;
                        $display("FAIL invariant_%s: gnt_o=%b found=%b req=%b, required one-hot/zero subset of req",
                                 t, gnt, gnt_found, req);
                    end
                end
                if (f && gnt_found) fair_cnt[gnt_idx]++;
            end
        end
    end

    initial begin
        int s_eq [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
        int s_w  [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
        int fair_exp [N] = '{3125, 1875, 625, 4375};

        foreach (fair_cnt[i]) fair_cnt[i] = 0;
        rst = 1'b1; allow = 1'b1; req = '0; weight = '0;
        wcur = 16'h1111;

        drive(1, 1, 4'hF, -1, "reset", 0, 0);
        drive(1, 1, 4'hF, -1, "reset", 0, 0);
        foreach (s_eq[i]) drive(0, 1, 4'hF, s_eq[i], "equal_weights", 0, 0);

        wcur = 16'h1213;
        foreach (s_w[i]) drive(0, 1, 4'hF, s_w[i], "weighted", 0, 0);

        wcur = 16'h1113;
        drive(1, 1, 4'hF, -1, "reset", 0, 0);
        drive(0, 1, 4'hF, 0, "drop", 0, 0);
        drive(0, 1, 4'hF, 0, "drop", 0, 0);
        drive(0, 1, 4'b0100, 2, "drop", 0, 0);
        drive(0, 1, 4'hF, 3, "drop_ptr", 0, 0);

        drive(1, 1, 4'hF, -1, "reset", 0, 0);
        drive(0, 1, 4'hF, 0, "allow", 0, 0);
        repeat (3) drive(0, 0, 4'hF, -1, "allow_off", 0, 0);
        drive(0, 1, 4'hF, 0, "allow_resume", 0, 0);
        drive(0, 1, 4'hF, 0, "allow_resume", 0, 0);
        drive(0, 1, 4'hF, 1, "allow_resume", 0, 0);

        drive(1, 1, 4'hF, -1, "reset", 0, 0);
        drive(0, 1, 4'hF, 0, "mid_reset", 0, 0);
        drive(1, 1, 4'hF, -1, "mid_reset", 0, 0);
        drive(0, 1, 4'b1010, 1, "post_reset", 0, 0);

        wcur = 16'h0000;
        drive(1, 1, 4'hF, -1, "reset", 0, 0);
        foreach (s_eq[i]) drive(0, 1, 4'hF, s_eq[i], "weight_zero", 0, 0);

        wcur = 16'h1113;
        drive(1, 1, 4'hF, -1, "reset", 0, 0);
        drive(0, 1, 4'hF, 0, "w_decrease", 0, 0);
        wcur = 16'h1112;
        drive(0, 1, 4'hF, 0, "w_decrease", 0, 0);
        drive(0, 1, 4'hF, 1, "w_decrease", 0, 0);

        wcur = 16'h1113;
        drive(1, 1, 4'hF, -1, "reset", 0, 0);
        drive(0, 1, 4'hF, 0, "hold", 0, 0);
        drive(0, 1, 4'h0, -1, "no_req", 0, 0);
        drive(0, 1, 4'hF, 0, "hold", 0, 0);
        drive(0, 1, 4'hF, 0, "hold", 0, 0);
        drive(0, 1, 4'hF, 1, "hold", 0, 0);

        // Random traffic checked against the model.
        for (int i = 0; i < 2000; i++) begin
            if (i % 50 == 0) wcur = 16'($urandom);
            drive(logic'($urandom_range(0, 63) == 0), logic'($urandom_range(0, 7) != 0),
                  4'($urandom_range(0, 15)), 0, "random", 1, 0);
        end

        // Effective weights 5,3,1,7: 10000 cycles is exactly 625 rounds of 16.
        wcur = 16'h7035;
        drive(1, 1, 4'hF, -1, "reset", 0, 0);
        for (int i = 0; i < 10000; i++) drive(0, 1, 4'hF, 0, "fairness", 1, 1);

        for (int i = 0; i < 100 && q_idx.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q_idx.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q_idx.size());
        end

        for (int i = 0; i < N; i++) begin
            checks++;
            if (fair_cnt[i] != fair_exp[i]) begin
                errors++;
                $display("FAIL share_%0d: got %0d grants, expected %0d", i, fair_cnt[i], fair_exp[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
